pwm_cap_rx: RTL and testbench

//  Receive-side counterpart of the PWM generator: decodes an external PWM waveform

---
 rtl/pwm_cap_rx.sv | 213 +++++++++++++++++++++
 tb/tb_pwm_cap_rx.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_cap_rx.sv
// -----------------------------------------------------------------------------
// pwm_cap_rx
// Decodes an external PWM waveform into a period and a high-time, both counted
// in pclk cycles. Input path: synchroniser -> glitch filter -> edge detect ->
// measurement FSM. Results are presented with a one-cycle valid pulse.
//
// Ports
//   pclk         in   1      clock
//   presetn      in   1      asynchronous active-low reset
//   i_pwm        in   1      external PWM input (asynchronous to pclk)
//   meas_en      in   1      1 = measure, 0 = abort and idle
//   meas_period  out  CNT_W  cycles between consecutive filtered rising edges
//   meas_high    out  CNT_W  cycles between a filtered rise and the next fall
//   meas_vld     out  1      one-cycle pulse, meas_period/meas_high updated
//   meas_ovf     out  1      one-cycle pulse, counter saturated, result dropped
//   meas_busy    out  1      FSM is in HIGH or LOW
// -----------------------------------------------------------------------------
module pwm_cap_rx #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic             pclk,
    input  logic             presetn,
    input  logic             i_pwm,
    input  logic             meas_en,
    output logic [CNT_W-1:0] meas_period,
    output logic [CNT_W-1:0] meas_high,
    output logic             meas_vld,
    output logic             meas_ovf,
    output logic             meas_busy
);

    localparam int FCNT_W = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);

    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [FCNT_W-1:0] FCNT_ZERO = {FCNT_W{1'b0}};
    localparam logic [FCNT_W-1:0] FCNT_ONE  = {{(FCNT_W-1){1'b0}}, 1'b1};
    localparam logic [FCNT_W-1:0] FILT_LAST = FCNT_W'(FILT_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } state_t;

    // Front end: synchroniser, filter and edge flags
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync_s;
    logic                   filt_q, filt_d;
    logic [FCNT_W-1:0]      fcnt_q, fcnt_d;
    logic                   filt_prev_q;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    // Measurement FSM
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       high_q, high_d;
    logic [CNT_W-1:0]       period_out_q, period_out_d;
    logic [CNT_W-1:0]       high_out_q, high_out_d;
    logic                   vld_q, vld_d;
    logic                   ovf_q, ovf_d;
    logic                   busy_q, busy_d;
    logic [CNT_W-1:0]       cnt_inc_s;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Next-state logic for synchroniser, glitch filter and edge flags
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_pwm};
        filt_d = filt_q;
        fcnt_d = FCNT_ZERO;
        // The level only flips after FILT_LEN consecutive samples disagree with
        // it; any agreeing sample restarts the run.
        if (sync_s != filt_q) begin
            if (fcnt_q == FILT_LAST) begin
                filt_d = sync_s;
                fcnt_d = FCNT_ZERO;
            end else begin
                filt_d = filt_q;
                fcnt_d = fcnt_q + FCNT_ONE;
            end
        end else begin
            filt_d = filt_q;
            fcnt_d = FCNT_ZERO;
        end
        // Both edges go through the same register, so durations are preserved.
        rise_d = filt_q & ~filt_prev_q;
        fall_d = ~filt_q & filt_prev_q;
    end

    // Front-end registers
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            sync_q      <= {SYNC_STAGES{1'b0}};
            filt_q      <= 1'b0;
            fcnt_q      <= FCNT_ZERO;
            filt_prev_q <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            filt_q      <= filt_d;
            fcnt_q      <= fcnt_d;
            filt_prev_q <= filt_q;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
        end
    end

    // Saturating increment: after a fall exactly at max the LOW phase still
    // sees max and reports an overflow instead of wrapping to a bogus period.
    assign cnt_inc_s = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);

    // Measurement FSM next-state and result logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_inc_s;
        high_d       = high_q;
        period_out_d = period_out_q;
        high_out_d   = high_out_q;
        vld_d        = 1'b0;
        ovf_d        = 1'b0;
        if (!meas_en) begin
            // Abort has priority over any edge in the same cycle.
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARM;
                    cnt_d   = CNT_ZERO;
                end
                ST_ARM: begin
                    // First rise only aligns the counter; nothing is reported.
                    if (rise_q) begin
                        state_d = ST_HIGH;
                        cnt_d   = CNT_ONE;
                    end else begin
                        state_d = ST_ARM;
                        cnt_d   = CNT_ZERO;
                    end
                end
                ST_HIGH: begin
                    if (fall_q) begin
                        high_d  = cnt_q;
                        state_d = ST_LOW;
                    end else if (cnt_q == CNT_MAX) begin
                        ovf_d   = 1'b1;
                        state_d = ST_ARM;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        state_d = ST_HIGH;
                    end
                end
                ST_LOW: begin
                    if (rise_q) begin
                        period_out_d = cnt_q;
                        high_out_d   = high_q;
                        vld_d        = 1'b1;
                        cnt_d        = CNT_ONE;
                        state_d      = ST_HIGH;
                    end else if (cnt_q == CNT_MAX) begin
                        ovf_d   = 1'b1;
                        state_d = ST_ARM;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        state_d = ST_LOW;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
        busy_d = (state_d == ST_HIGH) || (state_d == ST_LOW);
    end

    // Measurement FSM state and registered outputs
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= CNT_ZERO;
            high_q       <= CNT_ZERO;
            period_out_q <= CNT_ZERO;
            high_out_q   <= CNT_ZERO;
            vld_q        <= 1'b0;
            ovf_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            high_q       <= high_d;
            period_out_q <= period_out_d;
            high_out_q   <= high_out_d;
            vld_q        <= vld_d;
            ovf_q        <= ovf_d;
            busy_q       <= busy_d;
        end
    end

    assign meas_period = period_out_q;
    assign meas_high   = high_out_q;
    assign meas_vld    = vld_q;
    assign meas_ovf    = ovf_q;
    assign meas_busy   = busy_q;

endmodule

// File: tb/tb_pwm_cap_rx.sv
// -----------------------------------------------------------------------------
// tb_pwm_cap_rx
// Drives directed and random PWM waveforms into pwm_cap_rx (CNT_W=8 so that
// saturation is reachable quickly) and compares every cycle against a
// timestamp-based model of the measurement rules, plus literal expectations.
// -----------------------------------------------------------------------------
module tb_pwm_cap_rx;

    localparam int CNT_W = 8;
    localparam int SYNC  = 2;
    localparam int FILT  = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;
    localparam int HL    = SYNC + FILT;

    logic             pclk    = 1'b0;
    logic             presetn = 1'b0;
    logic             i_pwm   = 1'b0;
    logic             meas_en = 1'b0;
    logic [CNT_W-1:0] meas_period;
    logic [CNT_W-1:0] meas_high;
    logic             meas_vld;
    logic             meas_ovf;
    logic             meas_busy;

    int errors = 0;
    int checks = 0;
    int n_vld  = 0;
    int n_ovf  = 0;
    int last_per  = 0;
    int last_high = 0;

    pwm_cap_rx #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC), .FILT_LEN(FILT)) dut (
        .pclk        (pclk),
        .presetn     (presetn),
        .i_pwm       (i_pwm),
        .meas_en     (meas_en),
        .meas_period (meas_period),
        .meas_high   (meas_high),
        .meas_vld    (meas_vld),
        .meas_ovf    (meas_ovf),
        .meas_busy   (meas_busy)
    );

    always #5 pclk = ~pclk;

    // ---------------- reference model ----------------
    // The filtered level flips when the last FILT synchronised samples all
    // disagree with it. A filtered edge at posedge j is acted on at posedge j+2.
    // The counter value at posedge e is (e - load edge), saturated at CMAX.
    bit               hist [HL];
    bit               m_filt;
    int               m_ev1, m_ev2;   // 0 none, 1 rise, 2 fall
    int               m_st;           // 0 idle, 1 arm, 2 high, 3 low
    longint           cyc, m_load;
    int               m_hi, m_c;
    bit               m_all;
    logic [CNT_W-1:0] exp_period = '0;
    logic [CNT_W-1:0] exp_high   = '0;
    logic             exp_vld    = 1'b0;
    logic             exp_ovf    = 1'b0;
    logic             exp_busy   = 1'b0;

    always @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int k = 0; k < HL; k++) hist[k] = 1'b0;
            m_filt = 1'b0; m_ev1 = 0; m_ev2 = 0; m_st = 0;
            cyc = 0; m_load = 0; m_hi = 0;
            exp_period = '0; exp_high = '0;
            exp_vld = 1'b0; exp_ovf = 1'b0; exp_busy = 1'b0;
        end else begin
            cyc++;
            exp_vld = 1'b0;
            exp_ovf = 1'b0;
            m_c = (cyc - m_load > CMAX) ? CMAX : int'(cyc - m_load);
            if (!meas_en) begin
                m_st = 0;
            end else begin
                case (m_st)
                    0: m_st = 1;
                    1: if (m_ev2 == 1) begin m_load = cyc; m_st = 2; end
                    2: begin
                        if (m_ev2 == 2) begin m_hi = m_c; m_st = 3; end
                        else if (m_c == CMAX) begin exp_ovf = 1'b1; m_st = 1; end
                    end
                    3: begin
                        if (m_ev2 == 1) begin
                            exp_period = m_c[CNT_W-1:0];
                            exp_high   = m_hi[CNT_W-1:0];
                            exp_vld    = 1'b1;
                            m_load     = cyc;
                            m_st       = 2;
                        end else if (m_c == CMAX) begin
                            exp_ovf = 1'b1; m_st = 1;
                        end
                    end
                    default: m_st = 0;
                endcase
            end
            exp_busy = (m_st >= 2);
            m_ev2 = m_ev1;
            for (int k = HL - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = i_pwm;
            m_all = 1'b1;
            for (int k = SYNC; k < HL; k++) if (hist[k] == m_filt) m_all = 1'b0;
            m_ev1 = 0;
            if (m_all) begin
                m_filt = ~m_filt;
                m_ev1  = m_filt ? 1 : 2;
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: compare outputs at the falling edge, then tally pulses.
    task automatic step();
        @(negedge pclk);
        if (presetn) begin
            checks++;
            if ({meas_vld, meas_ovf, meas_busy, meas_period, meas_high} !==
                {exp_vld, exp_ovf, exp_busy, exp_period, exp_high}) begin
                errors++;
                $display("FAIL cycle %0d: got vld=%b ovf=%b busy=%b per=%0d high=%0d expected vld=%b ovf=%b busy=%b per=%0d high=%0d",
                         cyc, meas_vld, meas_ovf, meas_busy, meas_period, meas_high,
                         exp_vld, exp_ovf, exp_busy, exp_period, exp_high);
            end
            if (meas_vld) begin
                chk("vld_high_lt_period", (meas_high < meas_period) ? 1 : 0, 1);
                n_vld++;
                last_per  = meas_period;
                last_high = meas_high;
            end
            if (meas_ovf) n_ovf++;
        end
    endtask

    task automatic phase(input bit lvl, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            i_pwm = lvl;
        end
    endtask

    int v0, o0;

    initial begin
        // Reset state
        repeat (3) step();
        chk("rst_vld", meas_vld, 0);
        chk("rst_ovf", meas_ovf, 0);
        chk("rst_busy", meas_busy, 0);
        chk("rst_period", meas_period, 0);
        chk("rst_high", meas_high, 0);
        presetn = 1'b1;

        // 30 high / 70 low
        meas_en = 1'b1;
        phase(1'b0, 20);
        repeat (4) begin phase(1'b1, 30); phase(1'b0, 70); end
        phase(1'b1, 30);
        chk("t1_nvld", n_vld, 4);
        chk("t1_period", last_per, 100);
        chk("t1_high", last_high, 30);
        chk("t1_model_period", exp_period, 100);
        chk("t1_model_high", exp_high, 30);
        phase(1'b0, 70);

        // 2-cycle glitch inside the high phase is rejected
        v0 = n_vld;
        repeat (3) begin
            phase(1'b1, 10); phase(1'b0, 2); phase(1'b1, 18); phase(1'b0, 70);
        end
        phase(1'b1, 30);
        chk("t2_nvld", n_vld - v0, 4);
        chk("t2_period", last_per, 100);
        chk("t2_high", last_high, 30);
        phase(1'b0, 70);

        // 3-cycle glitch gets through
        phase(1'b1, 10); phase(1'b0, 3); phase(1'b1, 17);
        chk("t2g_period", last_per, 13);
        chk("t2g_high", last_high, 10);
        phase(1'b0, 70);

        // Stuck high after ARM -> overflow, then 10/30
        meas_en = 1'b0; phase(1'b0, 2); meas_en = 1'b1;
        v0 = n_vld; o0 = n_ovf;
        phase(1'b0, 20); phase(1'b1, 300);
        chk("t3_ovf", n_ovf - o0, 1);
        chk("t3_novld", n_vld - v0, 0);
        phase(1'b0, 30);
        repeat (3) begin phase(1'b1, 10); phase(1'b0, 30); end
        phase(1'b1, 10);
        chk("t3_nvld", n_vld - v0, 3);
        chk("t3_period", last_per, 40);
        chk("t3_high", last_high, 10);

        // Abort mid-HIGH, outputs hold, two rises needed after re-enable
        meas_en = 1'b0; v0 = n_vld;
        phase(1'b1, 3);
        chk("t4_busy", meas_busy, 0);
        chk("t4_hold_period", meas_period, 40);
        chk("t4_hold_high", meas_high, 10);
        phase(1'b1, 7); phase(1'b0, 30);
        meas_en = 1'b1;
        phase(1'b1, 10); phase(1'b0, 30);
        chk("t4_novld", n_vld - v0, 0);
        phase(1'b1, 10);
        chk("t4_nvld", n_vld - v0, 1);
        chk("t4_period", last_per, 40);

        // Asynchronous reset in the middle of LOW
        phase(1'b0, 15);
        #2 presetn = 1'b0; meas_en = 1'b0;
        #1;
        chk("t5_vld", meas_vld, 0);
        chk("t5_ovf", meas_ovf, 0);
        chk("t5_busy", meas_busy, 0);
        chk("t5_period", meas_period, 0);
        chk("t5_high", meas_high, 0);
        step();
        presetn = 1'b1; v0 = n_vld;
        phase(1'b1, 10); phase(1'b0, 10); phase(1'b1, 10);
        chk("t5_idle_busy", meas_busy, 0);
        chk("t5_idle_novld", n_vld - v0, 0);

        // Minimum phase: 3/3 accepted, 2/4 filtered -> overflow
        phase(1'b0, 20);
        meas_en = 1'b1; v0 = n_vld;
        phase(1'b0, 10);
        repeat (6) begin phase(1'b1, 3); phase(1'b0, 3); end
        phase(1'b1, 3); phase(1'b0, 10);
        chk("t6_nvld", n_vld - v0, 6);
        chk("t6_period", last_per, 6);
        chk("t6_high", last_high, 3);
        v0 = n_vld; o0 = n_ovf;
        repeat (50) begin phase(1'b1, 2); phase(1'b0, 4); end
        chk("t6_short_novld", n_vld - v0, 0);
        chk("t6_short_ovf", n_ovf - o0, 1);

        // Random waveform with occasional aborts
        for (int it = 0; it < 40; it++) begin
            phase(1'b1, $urandom_range(1, 150));
            phase(1'b0, $urandom_range(1, 150));
            if ($urandom_range(0, 9) == 0) begin
                meas_en = 1'b0;
                phase(i_pwm, $urandom_range(1, 3));
                meas_en = 1'b1;
            end
        end
        phase(1'b0, 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
